seg7_bcd_scan: RTL and testbench

Time-multiplexed 4-digit seven-segment driver that consumes the 12-bit, 3-digit packed BCD score produced by the binary-to-BCD converter. It latches a value on `load`, scans the digits at a parameterised rate, blanks leading zeros and can blink the whole display. It is the last stage before the board's anode and segment pins.

---
 rtl/seg7_bcd_scan_if.sv | 13 +
 rtl/seg7_bcd_scan.sv | 161 ++++++++++++++++
 tb/tb_seg7_bcd_scan.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/seg7_bcd_scan_if.sv
// Signal bundle between the score source and the seven-segment scanner.
// The master side drives the BCD value and controls; the slave side is the scanner.
interface seg7_bcd_scan_if;
  logic [11:0] bcd;
  logic        load;
  logic        blink;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  modport master (output bcd, load, blink, input an, seg, frame_done);
  modport slave  (input bcd, load, blink, output an, seg, frame_done);
endinterface

// File: rtl/seg7_bcd_scan.sv
// Time-multiplexed 4-digit seven-segment driver for a 3-digit packed BCD score.
// Slots: 0 = ones, 1 = tens, 2 = hundreds, 3 = always dark (keeps duty at 1/4).
// Leading zeros are blanked, nibbles above 9 show a dash, and the whole display
// can blink at a rate set in scan frames. an/seg are registered pin drivers.
module seg7_bcd_scan #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 128,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  seg7_bcd_scan_if.slave  bus
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Polarity masks: all patterns are built active-low, then flipped if needed.
  localparam logic [3:0] AN_XOR  = ACTIVE_LOW ? 4'h0 : 4'hF;
  localparam logic [6:0] SEG_XOR = ACTIVE_LOW ? 7'h00 : 7'h7F;
  localparam logic [6:0] SEG_DARK = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  typedef enum logic [1:0] {
    SLOT_ONES     = 2'd0,
    SLOT_TENS     = 2'd1,
    SLOT_HUNDREDS = 2'd2,
    SLOT_DARK     = 2'd3
  } slot_e;

  slot_e          idx_q, idx_d;
  logic [PW-1:0]  presc_q;
  logic           tc;
  logic [11:0]    disp_q;
  logic [FW-1:0]  frame_cnt_q;
  logic           phase_q;
  logic           frame_done_q;
  logic [3:0]     an_q, an_d;
  logic [6:0]     seg_q, seg_d;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h40;
      4'd1:    seg_of = 7'h79;
      4'd2:    seg_of = 7'h24;
      4'd3:    seg_of = 7'h30;
      4'd4:    seg_of = 7'h19;
      4'd5:    seg_of = 7'h12;
      4'd6:    seg_of = 7'h02;
      4'd7:    seg_of = 7'h78;
      4'd8:    seg_of = 7'h00;
      4'd9:    seg_of = 7'h10;
      default: seg_of = SEG_DASH;
    endcase
  endfunction

  assign tc = (presc_q == PW'(SCAN_DIV - 1));

  // Slot prescaler and slot index register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= SLOT_ONES;
    end else begin
      presc_q <= tc ? '0 : presc_q + 1'b1;
      idx_q   <= idx_d;
    end
  end

  // Next slot: advance at prescaler terminal count only.
  always_comb begin
    idx_d = idx_q;
    if (tc) begin
      unique case (idx_q)
        SLOT_ONES:     idx_d = SLOT_TENS;
        SLOT_TENS:     idx_d = SLOT_HUNDREDS;
        SLOT_HUNDREDS: idx_d = SLOT_DARK;
        SLOT_DARK:     idx_d = SLOT_ONES;
      endcase
    end
  end

  // Display register, reloaded on every edge with load high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           disp_q <= '0;
    else if (bus.load) disp_q <= bus.bcd;
  end

  // Frame-end pulse, raised on the edge that closes slot 3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_done_q <= 1'b0;
    else     frame_done_q <= tc && (idx_q == SLOT_DARK);
  end

  // Blink phase: toggles every BLINK_FRAMES frames; held visible while blink is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (!bus.blink) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (frame_done_q) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  // Digit select, leading-zero blanking and blink gating (active-low patterns).
  always_comb begin
    logic [3:0] hund, tens, ones, digit, an_pat;
    logic       lit;
    hund   = disp_q[11:8];
    tens   = disp_q[7:4];
    ones   = disp_q[3:0];
    digit  = ones;
    an_pat = 4'b1111;
    lit    = 1'b0;
    unique case (idx_q)
      SLOT_ONES: begin
        digit  = ones;
        an_pat = 4'b1110;
        lit    = 1'b1;
      end
      SLOT_TENS: begin
        digit  = tens;
        an_pat = 4'b1101;
        lit    = (hund != 4'd0) || (tens != 4'd0);
      end
      SLOT_HUNDREDS: begin
        digit  = hund;
        an_pat = 4'b1011;
        lit    = (hund != 4'd0);
      end
      SLOT_DARK: lit = 1'b0;
    endcase
    if (bus.blink && !phase_q) lit = 1'b0;
    an_d  = lit ? an_pat : 4'b1111;
    seg_d = lit ? seg_of(digit) : SEG_DARK;
  end

  // Registered pin drivers with polarity applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= 4'b1111 ^ AN_XOR;
      seg_q <= SEG_DARK ^ SEG_XOR;
    end else begin
      an_q  <= an_d ^ AN_XOR;
      seg_q <= seg_d ^ SEG_XOR;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_bcd_scan.sv
// Scoreboard bench for seg7_bcd_scan with SCAN_DIV=4, BLINK_FRAMES=2.
// Two instances share stimulus: one active-low, one active-high (inverted pins).
module tb_seg7_bcd_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] bcd = '0;
  logic        load = 1'b0;
  logic        blink = 1'b0;

  seg7_bcd_scan_if b0 ();
  seg7_bcd_scan_if b1 ();

  assign b0.bcd = bcd;  assign b0.load = load;  assign b0.blink = blink;
  assign b1.bcd = bcd;  assign b1.load = load;  assign b1.blink = blink;

  seg7_bcd_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .bus(b0));
  seg7_bcd_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
    string      tag;
  } exp_t;

  exp_t sb[$];
  event chk_now;
  int   n_vec = 0;
  int   n_bad = 0;
  int   k = 0;

  localparam int NV = 8;
  // Hand-derived active-low seg per slot (ones, tens, hundreds, dark); 7F = dark slot.
  logic [11:0] vec_bcd [NV] = '{12'h000, 12'h123, 12'h007, 12'h070,
                                12'h1A5, 12'h905, 12'hF00, 12'h456};
  logic [6:0]  seg_t [NV][4] = '{
    '{7'h40, 7'h7F, 7'h7F, 7'h7F},   // 000
    '{7'h30, 7'h24, 7'h79, 7'h7F},   // 123
    '{7'h78, 7'h7F, 7'h7F, 7'h7F},   // 007
    '{7'h40, 7'h78, 7'h7F, 7'h7F},   // 070
    '{7'h12, 7'h3F, 7'h79, 7'h7F},   // 1A5
    '{7'h12, 7'h40, 7'h10, 7'h7F},   // 905
    '{7'h40, 7'h40, 7'h3F, 7'h7F},   // F00
    '{7'h02, 7'h12, 7'h19, 7'h7F}    // 456
  };
  logic [3:0] an_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};

  task automatic tick();
    @(posedge clk);
    k++;
    #1;
  endtask

  task automatic push(input logic [3:0] an, input logic [6:0] seg, input logic fd,
                      input string tag);
    exp_t e;
    e.an = an; e.seg = seg; e.fd = fd;
    e.tag = $sformatf("%s k=%0d", tag, k);
    sb.push_back(e);
  endtask

  task automatic push_slot(input int v, input int slot, input logic fd,
                           input logic visible, input string tag);
    logic [6:0] s;
    s = visible ? seg_t[v][slot] : 7'h7F;
    push((s == 7'h7F) ? 4'b1111 : an_pat[slot], s, fd, tag);
  endtask

  // One 16-cycle frame showing vector cur; optional load of nxt issued after slot s==load_at.
  task automatic run_frame(input int cur, input int nxt, input int load_at);
    int v;
    for (int s = 0; s < 16; s++) begin
      tick();
      v = (load_at >= 0 && s >= load_at + 2) ? nxt : cur;
      push_slot(v, s / 4, (s == 15), 1'b1, $sformatf("scan_%03h", vec_bcd[v]));
      if (s == load_at) begin
        bcd  = vec_bcd[nxt];
        load = 1'b1;
      end
      if (s == load_at + 1) load = 1'b0;
    end
  endtask

  // Monitor: compares both instances against each popped expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_now);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (b0.an !== e.an || b0.seg !== e.seg || b0.frame_done !== e.fd) begin
          n_bad++;
          $display("FAIL %s lo: got an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                   e.tag, b0.an, b0.seg, b0.frame_done, e.an, e.seg, e.fd);
        end
        n_vec++;
        if (b1.an !== ~e.an || b1.seg !== ~e.seg || b1.frame_done !== e.fd) begin
          n_bad++;
          $display("FAIL %s hi: got an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                   e.tag, b1.an, b1.seg, b1.frame_done, ~e.an, ~e.seg, e.fd);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    repeat (2) @(posedge clk);
    #1;
    push(4'b1111, 7'h7F, 1'b0, "reset");
    @(posedge clk); #1;
    rst = 1'b0;
    k   = 0;

    // Scan, blanking, dash, mid-slot load (123 -> 456 during tens slot).
    run_frame(0, 1, 14);
    run_frame(1, 7, 4);
    run_frame(7, 2, 14);
    run_frame(2, 3, 14);
    run_frame(3, 4, 14);
    run_frame(4, 5, 14);
    run_frame(5, 6, 14);
    run_frame(6, 1, 14);

    // Blink on 123, enabled after edge 129: phase drops at 161 (dark pins 162..193),
    // back at 193 (visible 194), drops at 225 (dark from 226); blink released after 230.
    for (int kk = 129; kk <= 240; kk++) begin
      logic vis;
      tick();
      vis = !((k >= 162 && k <= 193) || (k >= 226 && k <= 230));
      push_slot(1, ((k - 1) % 16) / 4, (k % 16 == 0), vis, "blink");
      if (k == 129) blink = 1'b1;
      if (k == 230) blink = 1'b0;
    end

    // Asynchronous reset mid-slot, checked before any clock edge.
    tick(); push_slot(1, 0, 1'b0, 1'b1, "pre_rst");
    tick(); push_slot(1, 0, 1'b0, 1'b1, "pre_rst");
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    push(4'b1111, 7'h7F, 1'b0, "rst_async");
    ->chk_now;
    tick(); push(4'b1111, 7'h7F, 1'b0, "rst_hold");
    @(posedge clk); #1;
    rst = 1'b0;
    k   = 0;
    run_frame(0, 3, 14);
    run_frame(3, 3, -1);

    @(posedge clk); @(negedge clk); #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
